// File: rtl/addsub_serial_pkg.sv
// addsub_serial_pkg: mode encodings and FSM states shared by the serial add/sub block
package addsub_serial_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ADC = 2'b10;
    localparam logic [1:0] MODE_SBB = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: request operands, handshake and result/flag bundle of the serial add/sub
interface addsub_serial_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [1:0]       mode;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, cin, a, b,
        input  result, cout, ovf, zero, neg, busy, done
    );

    modport slave (
        input  start, mode, cin, a, b,
        output result, cout, ovf, zero, neg, busy, done
    );

endinterface

// File: rtl/addsub_serial_add_digit.sv
// add_digit: combinational DIGIT-bit ripple-carry adder shared by every digit step
module add_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/sub with carry/borrow chaining, start/busy/done handshake
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    addsub_serial_if.slave bus
);

    import addsub_serial_pkg::*;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] a_dig, b_dig, s_dig;
    logic             c_dig;
    logic             last;
    logic             is_sub, is_chain;

    // B is stored already inverted for subtraction, so one adder serves all four modes
    assign is_sub   = (bus.mode == MODE_SUB) || (bus.mode == MODE_SBB);
    assign is_chain = (bus.mode == MODE_ADC) || (bus.mode == MODE_SBB);
    assign a_dig    = a_q[cnt_q*DIGIT +: DIGIT];
    assign b_dig    = b_q[cnt_q*DIGIT +: DIGIT];
    assign last     = (cnt_q == CW'(N - 1));

    add_digit #(.DIGIT(DIGIT)) u_add (
        .a    (a_dig),
        .b    (b_dig),
        .cin  (carry_q),
        .s    (s_dig),
        .cout (c_dig)
    );

    // next state: latch on accept, one digit per RUN cycle, flags only on the last digit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.start) begin
                state_d = ST_RUN;
                cnt_d   = '0;
                a_d     = bus.a;
                b_d     = is_sub ? ~bus.b : bus.b;
                sub_d   = is_sub;
                carry_d = is_chain ? (bus.cin ^ is_sub) : is_sub;
            end
        end else begin
            result_d[cnt_q*DIGIT +: DIGIT] = s_dig;
            carry_d = c_dig;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            if (last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                cout_d  = c_dig ^ sub_q;
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_d  = (result_d == '0);
                neg_d   = result_d[WIDTH-1];
            end
        end
    end

    // state register; reset aborts any operation and presents a zero result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
    assign bus.neg    = neg_q;
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboard bench driving DIGIT=4, 16 and 1 instances with identical stimulus
module tb_addsub_serial;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cin = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;

    logic [15:0] rs [3];
    logic        co [3];
    logic        ov [3];
    logic        ze [3];
    logic        ng [3];
    logic        bz [3];
    logic        dn [3];
    int          done_cnt [3];
    exp_t        sbq [3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic ci, input logic [15:0] x,
                                   input logic [15:0] y, input int due);
        exp_t        e;
        logic [16:0] r;
        logic        sub, c;
        sub = m[0];
        c   = m[1] ? ci : 1'b0;
        r   = sub ? ({1'b0, x} - {1'b0, y} - 17'(c)) : ({1'b0, x} + {1'b0, y} + 17'(c));
        e.res  = r[15:0];
        e.cout = r[16];
        e.ovf  = sub ? ((x[15] != y[15]) && (r[15] != x[15])) : ((x[15] == y[15]) && (r[15] != x[15]));
        e.zero = (r[15:0] == 16'h0);
        e.neg  = r[15];
        e.due  = due;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 16 : 1;
        localparam int NG = 16 / DG;
        addsub_serial_if #(.WIDTH(16)) bus ();
        assign bus.start = start;
        assign bus.mode  = mode;
        assign bus.cin   = cin;
        assign bus.a     = a;
        assign bus.b     = b;
        assign rs[g] = bus.result;
        assign co[g] = bus.cout;
        assign ov[g] = bus.ovf;
        assign ze[g] = bus.zero;
        assign ng[g] = bus.neg;
        assign bz[g] = bus.busy;
        assign dn[g] = bus.done;
        addsub_serial #(.WIDTH(16), .DIGIT(DG)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        initial done_cnt[g] = 0;
        always @(negedge clk) begin
            exp_t e;
            if (dn[g]) begin
                chk($sformatf("d%0d_expected_done", DG), 32'(sbq[g].size() != 0), 1);
                if (sbq[g].size() != 0) begin
                    e = sbq[g].pop_front();
                    chk($sformatf("d%0d_result", DG), rs[g], e.res);
                    chk($sformatf("d%0d_cout", DG), co[g], e.cout);
                    chk($sformatf("d%0d_ovf", DG), ov[g], e.ovf);
                    chk($sformatf("d%0d_zero", DG), ze[g], e.zero);
                    chk($sformatf("d%0d_neg", DG), ng[g], e.neg);
                    chk($sformatf("d%0d_latency_cycle", DG), cyc, e.due);
                end
                done_cnt[g]++;
            end
            if (rst) sbq[g].delete();
            else if (start && !bz[g]) sbq[g].push_back(model(mode, cin, a, b, cyc + 1 + NG));
        end
    end

    task automatic wait_idle();
        int pend;
        pend = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #3;
            pend = 0;
            for (int i = 0; i < 3; i++) pend += sbq[i].size() + int'(bz[i]);
            if (pend == 0) break;
        end
        chk("idle_pending", pend, 0);
    endtask

    task automatic do_op(input logic [1:0] m, input logic ci, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] exp_res);
        @(posedge clk);
        #1;
        mode = m; cin = ci; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 2'($urandom); cin = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        wait_idle();
        for (int i = 0; i < 3; i++) chk($sformatf("op%0d_%h_%h_result_i%0d", m, x, y, i), rs[i], exp_res);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_result_i%0d", tag, i), rs[i], 16'h0);
            chk($sformatf("%s_zero_i%0d", tag, i), ze[i], 1'b1);
            chk($sformatf("%s_busy_i%0d", tag, i), bz[i], 1'b0);
            chk($sformatf("%s_done_i%0d", tag, i), dn[i], 1'b0);
            chk($sformatf("%s_flags_i%0d", tag, i), {co[i], ov[i], ng[i]}, 3'b000);
        end
    endtask

    initial begin
        int d0 [3];
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk_reset_state("reset");

        do_op(2'b00, 1'b0, 16'h1234, 16'h0FFF, 16'h2233);
        do_op(2'b01, 1'b0, 16'h0005, 16'h0007, 16'hFFFE);
        do_op(2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000);
        do_op(2'b10, 1'b1, 16'hFFFF, 16'h0000, 16'h0000);
        do_op(2'b11, 1'b1, 16'h0010, 16'h0010, 16'hFFFF);
        do_op(2'b10, 1'b0, 16'h8000, 16'h8000, 16'h0000);
        do_op(2'b11, 1'b0, 16'h8000, 16'h0001, 16'h7FFF);

        for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            mode = 2'($urandom); cin = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            int n;
            n = (i == 0) ? 4 : (i == 1) ? 1 : 16;
            chk($sformatf("cont_done_count_i%0d", i), done_cnt[i] - d0[i], (60 + n) / (n + 1));
        end

        @(posedge clk);
        #1;
        mode = 2'b00; a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk_reset_state("abort");
        for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
        repeat (20) @(posedge clk);
        #3;
        for (int i = 1; i < 3; i++) chk($sformatf("abort_no_done_i%0d", i), done_cnt[i] - d0[i], 0);
        chk("abort_no_done_i0", done_cnt[0] - d0[0], 0);
        do_op(2'b00, 1'b0, 16'h0001, 16'h0001, 16'h0002);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised digit-serial adder/subtractor; successor to the fixed 8-bit add/sub.
- Width set by WIDTH; DIGIT bits are processed per clock through one shared DIGIT-bit ripple adder.
- Supports carry/borrow chaining (ADC/SBB) for multi-precision arithmetic.
- Uses a start/busy/done handshake.
- Sits in the datapath wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 4: bits processed per clock. Latency N = WIDTH/DIGIT cycles.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request. Sampled only while busy=0.
- mode, input, 2: operation. 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin, input, 1: carry-in for ADC; borrow-in for SBB. Ignored for ADD/SUB.
- a, input, WIDTH: operand A. Latched on accepted start.
- b, input, WIDTH: operand B. Latched on accepted start.
- result, output, WIDTH: A op B. Valid from the done cycle, held until the next accepted start.
- cout, output, 1: carry-out (ADD/ADC) or borrow-out (SUB/SBB, =1 when borrow occurred).
- ovf, output, 1: two's-complement signed overflow.
- zero, output, 1: result == 0.
- neg, output, 1: result[WIDTH-1].
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse; result and flags valid.

Behaviour:
- Reset (rst=1 at a rising edge): state to IDLE; digit counter to 0.
  - Cleared: result, cout, ovf, busy, done, neg, operand/carry registers.
  - zero=1 (consistent with result 0).
  - rst overrides start in the same cycle.
  - rst mid-operation aborts the operation; no done is issued.
- FSM states: IDLE, RUN.
  - IDLE→RUN on start=1. RUN→IDLE after the last digit.
  - There is no separate DONE state; done is registered.
- Accept (edge k, IDLE, start=1):
  - Latch a, b, mode.
  - B' = b for ADD/ADC; B' = ~b for SUB/SBB.
  - Initial carry: ADD 0; SUB 1; ADC cin; SBB ~cin.
  - busy<=1, cnt<=0. Store a[WIDTH-1] and B'[WIDTH-1] for ovf.
- RUN, edges k+1..k+N: each edge processes digit cnt (LSB first).
  - DIGIT-bit add of A digit + B' digit + carry.
  - Write the sum into result digit cnt; register the digit carry; cnt increments.
  - Implementation is free to use shift registers instead of indexed slices; the visible timing is fixed.
- Completion (edge k+N): busy<=0, done<=1 for exactly one cycle. Flags update in the same edge:
  - cout = final carry (ADD/ADC) or ~final carry (SUB/SBB).
  - ovf = (a_msb == B'_msb) && (result_msb != a_msb).
  - zero and neg from the final result.
- Latency: done high N cycles after the edge that sampled start. Throughput: one operation per N+1 cycles; start is accepted in the done cycle, since busy=0 there.
- start while busy=1 is ignored, not queued. a/b/mode/cin changes while busy have no effect.
- During RUN, result holds partially-updated digits and flags hold the previous values. Consumers sample only on done.
- Result wraps modulo 2^WIDTH; the carry beyond the MSB appears only in cout.
- DIGIT == WIDTH is legal: N=1, done on the edge after accept.

Decomposition:
- Shared include header:
  - mode encodings MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ADC=2'b10, MODE_SBB=2'b11;
  - FSM state encodings ST_IDLE, ST_RUN.
- One sub-module: add_digit (combinational DIGIT-bit ripple adder; ports a, b, cin, s, cout, parametrised by DIGIT). Instantiated once in addsub_serial.
- Counter width: clog2(N), minimum 1 bit.

Test Plan:
- Default parameters throughout: WIDTH=16, DIGIT=4, N=4.
- ADD, a=0x1234, b=0x0FFF, start pulse → done exactly 4 cycles later; result=0x2233, cout=0, ovf=0, zero=0, neg=0.
- SUB, a=0x0005, b=0x0007 → result=0xFFFE, cout(borrow)=1, ovf=0, neg=1. ADD 0x7FFF+0x0001 → result=0x8000, ovf=1, cout=0.
- ADC cin=1, a=0xFFFF, b=0x0000 → result=0x0000, cout=1, zero=1. SBB cin=1, a=0x0010, b=0x0010 → result=0xFFFF, cout=1, ovf=0.
- start held high continuously with new operands every cycle → one done per 5 cycles. Operands seen on non-accept cycles are ignored. Results match only the operands present on each accept edge.
- rst=1 two cycles into an operation → next cycle busy=0, done=0, result=0, zero=1. No done pulse follows. A fresh ADD 0x0001+0x0001 then gives 0x0002.
- Re-run all cases with DIGIT=16 (N=1) and DIGIT=1 (N=16) → identical results/flags; done at 1 and 16 cycles respectively.
